// File: rtl/pool_stream_engine.sv
// pool_stream_engine
// ------------------
// Streaming 2-D pooling engine. Ifmap pixels arrive in raster order on an
// AXI-Stream with CH channels packed per beat; pooled ofmap pixels leave on a
// second AXI-Stream with the same packing. Kernel K, stride S, width W and
// height H are latched at cfg_start and may take any legal value up to the
// compile-time maxima.
//
// Handshake rule (both streams): a beat transfers on a rising clk edge where
// tvalid and tready are both high. A source holds tdata/tlast/tvalid stable
// from the cycle it raises tvalid until the transfer. tready may depend
// combinationally on the downstream tready, but never on tvalid.
//
// Optional feature macro: POOL_STREAM_AVG_EN
//   defined   : cfg_mode = 1 selects average pooling (K in {1,2,4} only);
//               accumulators and row buffer widen to DATA_W + 2*clog2(KMAX).
//   undefined : max pooling only, cfg_mode is ignored.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   cfg_start            one-cycle pulse, latches cfg_kernel/stride/width/
//                        height/mode when idle
//   s_axis_*             ifmap stream in (tdata, tvalid, tready)
//   m_axis_*             ofmap stream out (tdata, tvalid, tready, tlast)
//   busy                 a job is active
//   done                 one-cycle pulse after the last ofmap beat is taken
//   cfg_err              sticky, set by an illegal start, cleared by a legal one
//   dbg_state            current FSM state (0 idle, 1 run, 2 flush)

module pool_stream_engine #(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int KMAX   = 4,
  parameter int MAX_W  = 256,
  parameter int CNT_W  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [2:0]           cfg_kernel,
  input  logic [2:0]           cfg_stride,
  input  logic [CNT_W-1:0]     cfg_width,
  input  logic [CNT_W-1:0]     cfg_height,
  input  logic                 cfg_mode,
  input  logic [CH*DATA_W-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [CH*DATA_W-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [1:0]           dbg_state
);

`ifdef POOL_STREAM_AVG_EN
  localparam int EW = DATA_W + 2 * $clog2(KMAX);
`else
  localparam int EW = DATA_W;
`endif
  localparam int PW    = CH * EW;
  localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int CW    = CNT_W + 1;   // one spare bit so window-end sums cannot wrap

  localparam logic [2:0]    KMAX_L = 3'(KMAX);
  localparam logic [CW-1:0] MAXW_L = CW'(MAX_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic [2:0]           s_q, s_d;
  logic [CNT_W-1:0]     w_q, w_d;
  logic [CNT_W-1:0]     h_q, h_d;
  logic [CNT_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     row_q, row_d;
  logic [2:0]           col_ph_q, col_ph_d;
  logic [2:0]           row_ph_q, row_ph_d;
  logic [IDX_W-1:0]     col_win_q, col_win_d;
  logic [PW-1:0]        hacc_q, hacc_d;
  logic [CH*DATA_W-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
`ifdef POOL_STREAM_AVG_EN
  logic                 mode_q, mode_d;
`else
  logic                 unused_cfg_mode;
  assign unused_cfg_mode = cfg_mode;
`endif

  // One vertical partial result per window column position.
  logic [PW-1:0] rowbuf_q [MAX_W];
  logic [PW-1:0] rb_rd;
  logic          rb_we;

  // Per-channel reduction step: max, or sum in average mode.
  function automatic logic [EW-1:0] combine(input logic [EW-1:0] a,
                                            input logic [EW-1:0] b);
`ifdef POOL_STREAM_AVG_EN
    if (mode_q) return a + b;
`endif
    return (a > b) ? a : b;
  endfunction

  // Final per-channel value: average divides the K*K sum by a power of two.
  function automatic logic [DATA_W-1:0] scale(input logic [EW-1:0] v);
    logic [EW-1:0] sh;
    sh = v;
`ifdef POOL_STREAM_AVG_EN
    if (mode_q) begin
      if (k_q == 3'd4)      sh = v >> 4;
      else if (k_q == 3'd2) sh = v >> 2;
    end
`endif
    return sh[DATA_W-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Configuration legality
  // ---------------------------------------------------------------------
  logic          cfg_legal;
  logic [CW-1:0] cfg_k_ext;

  always_comb begin
    cfg_k_ext = CW'(cfg_kernel);
    cfg_legal = (cfg_kernel != 3'd0) && (cfg_kernel <= KMAX_L) &&
                (cfg_stride >= cfg_kernel) && (cfg_stride <= KMAX_L) &&
                (CW'(cfg_width) >= cfg_k_ext) && (CW'(cfg_width) <= MAXW_L) &&
                (CW'(cfg_height) >= cfg_k_ext);
`ifdef POOL_STREAM_AVG_EN
    if (cfg_mode && !((cfg_kernel == 3'd1) || (cfg_kernel == 3'd2) ||
                      (cfg_kernel == 3'd4)))
      cfg_legal = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // Window membership of the current input pixel. The window start is
  // col - col_phase; it is a real output window iff start + K <= W, which
  // is the same test as col < OW*S but needs no divider. It is the last
  // window of the row iff the next start would not fit.
  // ---------------------------------------------------------------------
  logic [CW-1:0] k_ext, s_ext, col_start, row_start;
  logic          col_ok, row_ok, col_lastw, row_lastw;
  logic          in_win, col_first, col_end, row_first, row_end;

  always_comb begin
    k_ext     = CW'(k_q);
    s_ext     = CW'(s_q);
    col_start = CW'(col_q) - CW'(col_ph_q);
    row_start = CW'(row_q) - CW'(row_ph_q);
    col_ok    = (col_start + k_ext) <= CW'(w_q);
    row_ok    = (row_start + k_ext) <= CW'(h_q);
    col_lastw = (col_start + k_ext + s_ext) > CW'(w_q);
    row_lastw = (row_start + k_ext + s_ext) > CW'(h_q);
    in_win    = (col_ph_q < k_q) && (row_ph_q < k_q) && col_ok && row_ok;
    col_first = (col_ph_q == 3'd0);
    row_first = (row_ph_q == 3'd0);
    col_end   = (col_ph_q == k_q - 3'd1);
    row_end   = (row_ph_q == k_q - 3'd1);
  end

  // ---------------------------------------------------------------------
  // Datapath: horizontal reduction, then vertical merge with the row buffer
  // ---------------------------------------------------------------------
  logic [PW-1:0]        hsum, vres;
  logic [CH*DATA_W-1:0] res_out;

  assign rb_rd = rowbuf_q[col_win_q];

  always_comb begin
    hsum    = '0;
    vres    = '0;
    res_out = '0;
    for (int c = 0; c < CH; c++) begin
      logic [EW-1:0] pe, hs, vr;
      pe = EW'(s_axis_tdata[c*DATA_W +: DATA_W]);
      hs = col_first ? pe : combine(hacc_q[c*EW +: EW], pe);
      vr = row_first ? hs : combine(rb_rd[c*EW +: EW], hs);
      hsum[c*EW +: EW]            = hs;
      vres[c*EW +: EW]            = vr;
      res_out[c*DATA_W +: DATA_W] = scale(vr);
    end
  end

  assign s_axis_tready = (state_q == ST_RUN) && (!out_valid_q || m_axis_tready);

  logic accept, last_col, last_row, col_wrap, row_wrap;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    col_ph_d    = col_ph_q;
    row_ph_d    = row_ph_q;
    col_win_d   = col_win_q;
    hacc_d      = hacc_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;
    rb_we       = 1'b0;
`ifdef POOL_STREAM_AVG_EN
    mode_d      = mode_q;
`endif
    accept   = s_axis_tvalid && s_axis_tready;
    last_col = (col_q == w_q - CNT_W'(1));
    last_row = (row_q == h_q - CNT_W'(1));
    col_wrap = (col_ph_q == s_q - 3'd1);
    row_wrap = (row_ph_q == s_q - 3'd1);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_legal) begin
            state_d   = ST_RUN;
            k_d       = cfg_kernel;
            s_d       = cfg_stride;
            w_d       = cfg_width;
            h_d       = cfg_height;
            col_d     = '0;
            row_d     = '0;
            col_ph_d  = '0;
            row_ph_d  = '0;
            col_win_d = '0;
            cfg_err_d = 1'b0;
`ifdef POOL_STREAM_AVG_EN
            mode_d    = cfg_mode;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          if (in_win) begin
            hacc_d = hsum;
            if (col_end) begin
              if (row_end) begin
                out_valid_d = 1'b1;
                out_data_d  = res_out;
                out_last_d  = col_lastw && row_lastw;
              end else begin
                rb_we = 1'b1;
              end
            end
          end
          if (last_col) begin
            col_d     = '0;
            col_ph_d  = '0;
            col_win_d = '0;
            row_d     = row_q + CNT_W'(1);
            row_ph_d  = row_wrap ? 3'd0 : row_ph_q + 3'd1;
            if (last_row) state_d = ST_FLUSH;
          end else begin
            col_d     = col_q + CNT_W'(1);
            col_ph_d  = col_wrap ? 3'd0 : col_ph_q + 3'd1;
            col_win_d = col_win_q + IDX_W'(col_wrap);
          end
        end
      end

      ST_FLUSH: begin
        if (!out_valid_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      s_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      col_win_q   <= '0;
      hacc_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef POOL_STREAM_AVG_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      s_q         <= s_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      col_ph_q    <= col_ph_d;
      row_ph_q    <= row_ph_d;
      col_win_q   <= col_win_d;
      hacc_q      <= hacc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
`ifdef POOL_STREAM_AVG_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // Row buffer needs no reset: window row 0 always writes before any read.
  always_ff @(posedge clk) begin
    if (rb_we) rowbuf_q[col_win_q] <= vres;
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pool_stream_engine.sv
module tb_pool_stream_engine;
  localparam int DATA_W = 8;
  localparam int CH     = 4;
  localparam int KMAX   = 4;
  localparam int MAX_W  = 256;
  localparam int CNT_W  = 9;
  localparam int DW     = CH * DATA_W;
  localparam int BUDGET = 20000;
  localparam logic [1:0] RUN_ST = 2'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic [2:0]       cfg_kernel, cfg_stride;
  logic [CNT_W-1:0] cfg_width, cfg_height;
  logic             cfg_mode;
  logic [DW-1:0]    s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic             busy, done, cfg_err;
  logic [1:0]       dbg_state;

  pool_stream_engine #(.DATA_W(DATA_W), .CH(CH), .KMAX(KMAX), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_kernel(cfg_kernel),
    .cfg_stride(cfg_stride), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_mode(cfg_mode), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            vectors, miscompares;
  logic [DW-1:0] img_q[$];
  logic [DW:0]   exp_q[$];   // {tlast, tdata}
  logic [DW:0]   got_q[$];
  int            done_cnt, stall_viol, in_stall, timed_out, accepted;

  // Reference model: pool the stored image directly from the window rules.
  task automatic build_expected(input int k, input int s, input int w, input int h, input int mode);
    int ow, oh, acc, v;
    logic [DW-1:0] px, od;
    exp_q.delete();
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        od = '0;
        for (int c = 0; c < CH; c++) begin
          acc = 0;
          for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
              px = img_q[(oy * s + dy) * w + ox * s + dx];
              v  = int'(px[c*DATA_W +: DATA_W]);
              if (mode != 0) acc = acc + v;
              else if (v > acc) acc = v;
            end
          if (mode != 0) acc = acc / (k * k);
          od[c*DATA_W +: DATA_W] = acc[DATA_W-1:0];
        end
        exp_q.push_back({(oy == oh - 1) && (ox == ow - 1), od});
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int k, input int s, input int w, input int h, input int mode);
    @(negedge clk);
    cfg_kernel = 3'(k);
    cfg_stride = 3'(s);
    cfg_width  = CNT_W'(w);
    cfg_height = CNT_W'(h);
    cfg_mode   = mode[0];
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    cfg_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams img_q into the DUT and collects ofmap beats. Inputs change at
  // negedge; handshakes are observed 1 ns later and complete at the next
  // posedge. stall_mode: 0 ready always, 1 ready 1-of-3, 2 random.
  task automatic run_job(input int gap, input int stall_mode, input int abort_after, input int inject);
    int idx, cyc, npix;
    logic prev_hold;
    logic [DW:0] prev_beat;
    got_q.delete();
    done_cnt = 0; stall_viol = 0; in_stall = 0; timed_out = 0; accepted = 0;
    idx = 0; cyc = 0; prev_hold = 1'b0; prev_beat = '0;
    npix = img_q.size();
    while (1) begin
      case (stall_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = (cyc % 3 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      s_axis_tvalid = (idx < npix) && ((gap == 0) || ($urandom_range(0, 3) != 0));
      s_axis_tdata  = (idx < npix) ? img_q[idx] : DW'($urandom);
      if ((inject != 0) && (idx == 3)) begin
        cfg_start = 1'b1;
        cfg_kernel = 3'd0;
      end else begin
        cfg_start = 1'b0;
      end
      #1;
      if (prev_hold && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} !== prev_beat)))
        stall_viol++;
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_beat = {m_axis_tlast, m_axis_tdata};
      if (s_axis_tvalid && !s_axis_tready && (dbg_state == RUN_ST)) in_stall++;
      if (s_axis_tvalid && s_axis_tready) begin
        idx++;
        accepted++;
      end
      if (done) done_cnt++;
      if (done || ((abort_after > 0) && (idx >= abort_after))) break;
      if (cyc >= BUDGET) begin
        timed_out = 1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic setup_case1();
    logic [5:0] ch0_rows [6];
    logic [5:0] ch1_rows [6];
    logic [5:0] r0, r1;
    ch0_rows = '{6'b100000, 6'b001010, 6'b010100, 6'b110000, 6'b101100, 6'b001010};
    ch1_rows = '{6'b000110, 6'b000000, 6'b010000, 6'b100000, 6'b110101, 6'b011101};
    img_q.delete();
    for (int r = 0; r < 6; r++) begin
      r0 = ch0_rows[r];
      r1 = ch1_rows[r];
      for (int c = 0; c < 6; c++)
        img_q.push_back({8'($urandom), 8'($urandom), 7'd0, r1[5-c], 7'd0, r0[5-c]});
    end
  endtask

  task automatic setup_random(input int w, input int h);
    img_q.delete();
    for (int i = 0; i < w * h; i++) img_q.push_back(DW'($urandom));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, done, cfg_err, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b srdy=%b mvld=%b mlast=%b mdata=%h, required all 0",
               busy, done, cfg_err, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, s_axis_tready, m_axis_tvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b srdy=%b mvld=%b, required 000", busy, s_axis_tready, m_axis_tvalid);
    end
  endtask

  task automatic test_case1();
    logic [8:0] ch0_exp, ch1_exp;
    ch0_exp = 9'b111_110_111;
    ch1_exp = 9'b011_100_111;
    setup_case1();
    build_expected(2, 2, 6, 6, 0);
    do_start(2, 2, 6, 6, 0);
    run_job(0, 0, 0, 0);
    vectors++;
    if (got_q.size() !== 9) begin
      miscompares++;
      $display("FAIL case1_count: got %0d beats, required 9", got_q.size());
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL case1_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
      vectors++;
      if ({got_q[i][15:8], got_q[i][7:0]} !== {7'd0, ch1_exp[8-i], 7'd0, ch0_exp[8-i]}) begin
        miscompares++;
        $display("FAIL case1_spec%0d: got ch1/ch0 %h, required %h", i, got_q[i][15:0],
                 {7'd0, ch1_exp[8-i], 7'd0, ch0_exp[8-i]});
      end
    end
    vectors++;
    if ((done_cnt !== 1) || (timed_out !== 0)) begin
      miscompares++;
      $display("FAIL case1_done: got done=%0d timeout=%0d, required 1/0", done_cnt, timed_out);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL case1_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_case2();
    logic [7:0] req [4];
    req = '{8'd22, 8'd26, 8'd62, 8'd66};
    img_q.delete();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) img_q.push_back({CH{8'(r * 10 + c)}});
    build_expected(3, 4, 10, 10, 0);
    do_start(3, 4, 10, 10, 0);
    run_job(0, 0, 0, 0);
    vectors++;
    if (got_q.size() !== 4) begin
      miscompares++;
      $display("FAIL case2_count: got %0d beats, required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== {i == 3, {CH{req[i]}}}) begin
        miscompares++;
        $display("FAIL case2_beat%0d: got %h, required %h", i, got_q[i], {i == 3, {CH{req[i]}}});
      end
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL case2_model%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ((accepted !== 100) || (in_stall !== 0) || (done_cnt !== 1)) begin
      miscompares++;
      $display("FAIL case2_flow: got accepted=%0d stalls=%0d done=%0d, required 100/0/1", accepted, in_stall, done_cnt);
    end
  endtask

  task automatic test_stall();
    setup_case1();
    build_expected(2, 2, 6, 6, 0);
    do_start(2, 2, 6, 6, 0);
    run_job(1, 1, 0, 0);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ((stall_viol !== 0) || (done_cnt !== 1) || (timed_out !== 0)) begin
      miscompares++;
      $display("FAIL stall_hold: got unstable=%0d done=%0d timeout=%0d, required 0/1/0", stall_viol, done_cnt, timed_out);
    end
  endtask

  task automatic test_illegal();
    int tbl [6][4];
    tbl = '{'{3, 2, 6, 6}, '{0, 1, 6, 6}, '{2, 2, 1, 6}, '{2, 2, 6, 1}, '{2, 5, 6, 6}, '{2, 2, 300, 6}};
    for (int t = 0; t < 6; t++) begin
      pulse_reset();
      do_start(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], 0);
      vectors++;
      if ({cfg_err, busy, s_axis_tready} !== 3'b100) begin
        miscompares++;
        $display("FAIL illegal%0d: got err/busy/srdy=%b, required 100", t, {cfg_err, busy, s_axis_tready});
      end
    end
    setup_case1();
    build_expected(2, 2, 6, 6, 0);
    do_start(2, 2, 6, 6, 0);
    vectors++;
    if ({cfg_err, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL illegal_recover: got err/busy=%b, required 01", {cfg_err, busy});
    end
    run_job(0, 0, 0, 0);
    vectors++;
    if ((got_q.size() !== exp_q.size()) || (done_cnt !== 1)) begin
      miscompares++;
      $display("FAIL illegal_job_count: got %0d beats done=%0d, required %0d/1", got_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL illegal_job_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midjob();
    setup_case1();
    build_expected(2, 2, 6, 6, 0);
    do_start(2, 2, 6, 6, 0);
    run_job(0, 0, 10, 0);
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    vectors++;
    if ({busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got busy=%b done=%b srdy=%b mvld=%b mlast=%b mdata=%h, required all 0",
               busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ((done_cnt !== 0) || (done !== 1'b0)) begin
      miscompares++;
      $display("FAIL midreset_done: got done pulses=%0d, required 0", done_cnt);
    end
    setup_case1();
    build_expected(2, 2, 6, 6, 0);
    do_start(2, 2, 6, 6, 0);
    run_job(0, 0, 0, 0);
    vectors++;
    if ((got_q.size() !== 9) || (done_cnt !== 1)) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d beats done=%0d, required 9/1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midreset_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int tbl [4][4];
    tbl = '{'{1, 1, 5, 3}, '{4, 4, 256, 4}, '{3, 3, 3, 3}, '{2, 3, 7, 8}};
    for (int t = 0; t < 4; t++) begin
      setup_random(tbl[t][2], tbl[t][3]);
      build_expected(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], 0);
      do_start(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], 0);
      run_job(t % 2, t % 3, 0, 0);
      vectors++;
      if ((got_q.size() !== exp_q.size()) || (done_cnt !== 1) || (timed_out !== 0)) begin
        miscompares++;
        $display("FAIL bound%0d_count: got %0d beats done=%0d, required %0d/1", t, got_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL bound%0d_beat%0d: got %h, required %h", t, i, got_q[i], exp_q[i]);
        end
        if (t == 0) begin
          vectors++;
          if (got_q[i][DW-1:0] !== img_q[i]) begin
            miscompares++;
            $display("FAIL passthru%0d: got %h, required %h", i, got_q[i][DW-1:0], img_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      setup_random(8, 6);
      build_expected(2, 2, 8, 6, 0);
      do_start(2, 2, 8, 6, 0);
      vectors++;
      if ((busy !== 1'b1) || (dbg_state !== RUN_ST)) begin
        miscompares++;
        $display("FAIL b2b%0d_start: got busy=%b state=%0d, required 1/1", j, busy, dbg_state);
      end
      run_job(0, 0, 0, 0);
      vectors++;
      if ((got_q.size() !== exp_q.size()) || (done_cnt !== 1)) begin
        miscompares++;
        $display("FAIL b2b%0d_count: got %0d beats done=%0d, required %0d/1", j, got_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b%0d_beat%0d: got %h, required %h", j, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int k, s, w, h;
    for (int j = 0; j < 8; j++) begin
      k = $urandom_range(1, KMAX);
      s = $urandom_range(k, KMAX);
      w = $urandom_range(k, 20);
      h = $urandom_range(k, 10);
      setup_random(w, h);
      build_expected(k, s, w, h, 0);
      do_start(k, s, w, h, 0);
      run_job(1, 2, 0, (j == 0) ? 1 : 0);
      vectors++;
      if ((got_q.size() !== exp_q.size()) || (done_cnt !== 1) || (timed_out !== 0) || (stall_viol !== 0)) begin
        miscompares++;
        $display("FAIL rand%0d_count: K=%0d S=%0d W=%0d H=%0d got %0d beats done=%0d unstable=%0d, required %0d/1/0",
                 j, k, s, w, h, got_q.size(), done_cnt, stall_viol, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d: got %h, required %h", j, i, got_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (cfg_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_busy_start: got cfg_err=%b, required 0", j, cfg_err);
      end
    end
  endtask

`ifdef POOL_STREAM_AVG_EN
  task automatic test_avg();
    img_q.delete();
    img_q.push_back({CH{8'd10}});
    img_q.push_back({CH{8'd20}});
    img_q.push_back({CH{8'd30}});
    img_q.push_back({CH{8'd41}});
    do_start(2, 2, 2, 2, 1);
    run_job(0, 0, 0, 0);
    vectors++;
    if ((got_q.size() !== 1) || ((got_q.size() == 1) && (got_q[0] !== {1'b1, {CH{8'd25}}}))) begin
      miscompares++;
      $display("FAIL avg_k2: got %0d beats first %h, required 1 beat %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, {1'b1, {CH{8'd25}}});
    end
    for (int j = 0; j < 2; j++) begin
      setup_random(8, 8);
      build_expected(4 >> j, 4 >> j, 8, 8, 1);
      do_start(4 >> j, 4 >> j, 8, 8, 1);
      run_job(1, 2, 0, 0);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
        miscompares++;
        $display("FAIL avg_rand%0d_count: got %0d, required %0d", j, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL avg_rand%0d_beat%0d: got %h, required %h", j, i, got_q[i], exp_q[i]);
        end
      end
    end
    do_start(3, 3, 6, 6, 1);
    vectors++;
    if ({cfg_err, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL avg_k3_illegal: got err/busy=%b, required 10", {cfg_err, busy});
    end
  endtask
`else
  task automatic test_mode_ignored();
    setup_random(6, 6);
    build_expected(3, 3, 6, 6, 0);
    do_start(3, 3, 6, 6, 1);
    vectors++;
    if ({cfg_err, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL mode_ignored_start: got err/busy=%b, required 01", {cfg_err, busy});
    end
    run_job(0, 0, 0, 0);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL mode_ignored_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mode_ignored_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_kernel = '0;
    cfg_stride = '0;
    cfg_width = '0;
    cfg_height = '0;
    cfg_mode = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_case1();
    test_case2();
    test_stall();
    test_illegal();
    test_reset_midjob();
    test_boundary();
    test_back_to_back();
    test_random();
`ifdef POOL_STREAM_AVG_EN
    test_avg();
`else
    test_mode_ignored();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pool_stream_engine.md
Name: pool_stream_engine

Overview:
- Parametrised streaming pooling engine for the accelerator datapath.
- Consumes the ifmap AXI-Stream with CH channels packed per beat, in raster order.
- Produces the pooled ofmap AXI-Stream with the same packing.
- Supports runtime kernel size, stride, ifmap width and ifmap height, up to the compile-time maxima. Configuration comes from the AXI-Lite control block.

Parameters:
DATA_W, 8, bits per channel element (unsigned)
CH, 4, channels packed per stream beat
KMAX, 4, maximum kernel size and stride
MAX_W, 256, maximum ifmap width
CNT_W, 9, width of the width/height configuration fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_start  in  1  one-cycle pulse; latches the cfg_* fields
cfg_kernel  in  3  kernel size K
cfg_stride  in  3  stride S
cfg_width  in  CNT_W  ifmap width W
cfg_height  in  CNT_W  ifmap height H
cfg_mode  in  1  0 = max, 1 = average (average only with the optional feature)
s_axis_tdata  in  CH*DATA_W  ifmap pixel; channel c occupies bits [c*DATA_W +: DATA_W]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  CH*DATA_W  ofmap pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  asserted on the last ofmap pixel
busy  out  1  a job is active
done  out  1  one-cycle pulse after the last output beat is accepted
cfg_err  out  1  sticky; set when an illegal configuration is started

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; counters cleared. Reset mid-job aborts the job with no done pulse.
- Legal configuration:
  - 1 <= K <= KMAX
  - K <= S <= KMAX
  - K <= W <= MAX_W
  - K <= H
- Illegal cfg_start: sets cfg_err and stays in IDLE. A legal cfg_start clears cfg_err.
- Output dimensions: OW = (W-K)/S + 1 and OH = (H-K)/S + 1, integer floor.
- FSM states:
  - IDLE: s_axis_tready = 0. A legal cfg_start goes to RUN with busy = 1. cfg_start while busy is ignored.
  - RUN: accepts W*H beats, tracked by col/row counters and col/row phase counters (phase wraps at S).
    - A pixel is in a window iff col_phase < K, row_phase < K, col < OW*S and row < OH*S.
    - All other pixels are accepted and discarded.
  - RUN exits to FLUSH when the last input beat is accepted.
  - FLUSH: waits until the output register is empty, then pulses done, clears busy and returns to IDLE.
- Window accumulation:
  - The horizontal accumulator takes the per-channel max over the K window columns.
  - On window column K-1 it combines with row buffer entry [col/S], which holds MAX_W/1 entries of CH*DATA_W each.
  - In window row 0 the result is written to the entry. Otherwise the result is the max of the entry and the accumulator.
  - In window row K-1, window column K-1 the result is loaded into the output register instead of the entry.
- Output register:
  - One stage.
  - s_axis_tready = (state == RUN) && (!m_axis_tvalid || m_axis_tready).
  - Latency: 1 cycle from the completing input beat to m_axis_tvalid.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- m_axis_tlast: on ofmap pixel OW*OH-1.
- K = 1, S = 1: pure passthrough, one output per input.
- Back-to-back: a new cfg_start is accepted the cycle after done.
- Arithmetic: max is unsigned per-channel compare; there is no cross-channel interaction.

Optional Feature:
- Macro: POOL_STREAM_AVG_EN.
- Defined:
  - cfg_mode = 1 selects average mode.
  - Per-channel sums use width DATA_W + 2*clog2(KMAX). The row buffer is widened to match.
  - Output = sum >> (2*log2 K), truncated to DATA_W.
  - Average mode is legal only for K in {1, 2, 4}. Any other K with cfg_mode = 1 sets cfg_err.
- Undefined:
  - cfg_mode is ignored; max only.
  - No sum hardware; the row buffer is DATA_W per channel.

Test Plan:
1. CH=2, K=2, S=2, W=H=6, max, binary ifmaps:
   - ch0 rows = 100000/001010/010100/110000/101100/001010
   - ch1 rows = 000110/000000/010000/100000/110101/011101
   - Required 9 outputs: ch0 = 1 1 1 / 1 1 0 / 1 1 1, ch1 = 0 1 1 / 1 0 0 / 1 1 1
   - tlast on beat 9; done once.
2. K=3, S=4, W=H=10, ifmap value = row*10 + col:
   - OW = OH = 2; outputs = 22, 26, 62, 66 on every channel.
   - 100 inputs accepted; discarded pixels do not stall the stream.
3. Case 1 with m_axis_tready toggling 1-of-3 cycles:
   - Identical data; no dropped or duplicated beat; tdata stable while stalled.
4. Illegal starts: K=3, S=2 -> cfg_err=1, busy=0, s_axis_tready=0. Then a legal K=2, S=2 start -> cfg_err=0 and the job runs.
5. Assert rst after 10 inputs of case 1:
   - All outputs return to 0 immediately.
   - A restarted case 1 produces the correct 9 outputs.
6. POOL_STREAM_AVG_EN, K=2, S=2, W=H=2, inputs 10, 20, 30, 41:
   - Output 25 (101 >> 2).
   - K=3 with cfg_mode=1 -> cfg_err=1.
